// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: MIPS-style execute stage with a registered EX/MEM output.
//   clk, rst           single clock, synchronous active-high reset
//   in_valid/in_ready  ID/EX handshake; op selects ALU, mul/div or HI/LO move
//   rs_data, rt_data   operands; imm/sign_ext/alu_src build operand B
//   reg_dst, rd, rt    destination select; branch flags a branch-on-equal
//   shamt              shift amount; pc_plus4 is the sequential PC
//   out_valid/out_ready EX/MEM handshake; result, write_reg (0 = no writeback),
//                      branch_taken, branch_target form the output register
//   busy               high while a multiply or divide is running
module exe_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [15:0]       imm,
  input  logic              sign_ext,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic              branch,
  input  logic [4:0]        shamt,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rt,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [REG_AW-1:0] write_reg,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              busy
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MULT  = 4'd10;
  localparam logic [3:0] OP_MULTU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_MFHI  = 4'd14;
  localparam logic [3:0] OP_MFLO  = 4'd15;

  localparam int CNT_MAX = (DATA_W > MUL_CYCLES) ? DATA_W : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t              state;
  logic [DATA_W-1:0]   hi, lo;
  logic [CNT_W-1:0]    cnt;

  // Raw operands captured at accept (multiplier inputs; src_a also keeps
  // the dividend for the divide-by-zero result).
  logic [DATA_W-1:0]   src_a, src_b;
  logic                mul_signed;

  // Restoring divider state, working on operand magnitudes.
  logic [DATA_W-1:0]   rem, quo, dvsr;
  logic                neg_q, neg_r, div_zero;

  // Operand / ALU datapath
  logic [DATA_W-1:0]   ext_imm, opnd_b, alu_res;
  logic                shift_big;
  logic                accept, is_muldiv, is_div, op_signed;
  logic [REG_AW-1:0]   wr_sel;
  logic                br_taken;
  logic [DATA_W-1:0]   br_tgt;
  logic                neg_a, neg_b;
  logic [DATA_W-1:0]   mag_a, mag_b;

  // Multiply / divide datapath
  logic [2*DATA_W-1:0] mul_ea, mul_eb, prod;
  logic [DATA_W:0]     rem_sh, diff;
  logic [DATA_W-1:0]   rem_nx, quo_nx, q_fin, r_fin;

  // A 17-bit value whose top bit is the chosen fill bit, widened as signed.
  assign ext_imm   = DATA_W'($signed({sign_ext & imm[15], imm}));
  assign opnd_b    = alu_src ? ext_imm : rt_data;
  assign shift_big = ({27'b0, shamt} >= 32'(DATA_W));

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);

  assign is_muldiv = (op >= OP_MULT) && (op <= OP_DIVU);
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);

  assign wr_sel    = branch ? '0 : (reg_dst ? rd : rt);
  assign br_taken  = branch && (rs_data == rt_data);
  assign br_tgt    = pc_plus4 + (ext_imm << 2);

  assign neg_a     = op_signed & rs_data[DATA_W-1];
  assign neg_b     = op_signed & rt_data[DATA_W-1];
  assign mag_a     = neg_a ? -rs_data : rs_data;
  assign mag_b     = neg_b ? -rt_data : rt_data;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = rs_data + opnd_b;
      OP_SUB:  alu_res = rs_data - opnd_b;
      OP_AND:  alu_res = rs_data & opnd_b;
      OP_OR:   alu_res = rs_data | opnd_b;
      OP_XOR:  alu_res = rs_data ^ opnd_b;
      OP_NOR:  alu_res = ~(rs_data | opnd_b);
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(rs_data) < $signed(opnd_b))};
      OP_SLL:  alu_res = shift_big ? '0 : (opnd_b << shamt);
      OP_SRL:  alu_res = shift_big ? '0 : (opnd_b >> shamt);
      OP_SRA:  alu_res = shift_big ? {DATA_W{opnd_b[DATA_W-1]}}
                                   : DATA_W'($signed(opnd_b) >>> shamt);
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // Extending both factors to 2*DATA_W makes the truncated product correct
  // for signed and unsigned alike.
  assign mul_ea = mul_signed ? {{DATA_W{src_a[DATA_W-1]}}, src_a} : {{DATA_W{1'b0}}, src_a};
  assign mul_eb = mul_signed ? {{DATA_W{src_b[DATA_W-1]}}, src_b} : {{DATA_W{1'b0}}, src_b};
  assign prod   = mul_ea * mul_eb;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign rem_sh = {rem, quo[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, dvsr};
  assign rem_nx = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_nx = {quo[DATA_W-2:0], ~diff[DATA_W]};

  // Divide by zero bypasses the sign fix-up; most-negative / -1 falls out
  // of the magnitude path naturally (quotient wraps back to the dividend).
  always_comb begin
    if (div_zero) begin
      q_fin = '1;
      r_fin = src_a;
    end else begin
      q_fin = neg_q ? -quo_nx : quo_nx;
      r_fin = neg_r ? -rem_nx : rem_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      result        <= '0;
      write_reg     <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      hi            <= '0;
      lo            <= '0;
      cnt           <= '0;
      src_a         <= '0;
      src_b         <= '0;
      mul_signed    <= 1'b0;
      rem           <= '0;
      quo           <= '0;
      dvsr          <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      div_zero      <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (is_muldiv) begin
              cnt        <= is_div ? CNT_W'(DATA_W - 1) : CNT_W'(MUL_CYCLES - 1);
              src_a      <= rs_data;
              src_b      <= rt_data;
              mul_signed <= op_signed;
              rem        <= '0;
              quo        <= mag_a;
              dvsr       <= mag_b;
              neg_q      <= neg_a ^ neg_b;
              neg_r      <= neg_a;
              div_zero   <= (rt_data == '0);
              state      <= is_div ? DIV : MUL;
            end else begin
              out_valid     <= 1'b1;
              result        <= alu_res;
              write_reg     <= wr_sel;
              branch_taken  <= br_taken;
              branch_target <= br_tgt;
            end
          end
        end

        MUL: begin
          if (cnt == '0) begin
            hi            <= prod[2*DATA_W-1:DATA_W];
            lo            <= prod[DATA_W-1:0];
            out_valid     <= 1'b1;
            result        <= prod[DATA_W-1:0];
            write_reg     <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            state         <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          if (cnt == '0) begin
            hi            <= r_fin;
            lo            <= q_fin;
            out_valid     <= 1'b1;
            result        <= q_fin;
            write_reg     <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            state         <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Bench for exe_stage_pipe: directed operations, a transaction-level model
// checked against the DUT every cycle, and literal expectations per vector.
module tb_exe_stage_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = '0;
  logic [DW-1:0] rs_data = '0;
  logic [DW-1:0] rt_data = '0;
  logic [15:0]   imm = '0;
  logic          sign_ext = 1'b0;
  logic          alu_src = 1'b0;
  logic          reg_dst = 1'b0;
  logic          branch = 1'b0;
  logic [4:0]    shamt = '0;
  logic [AW-1:0] rd = '0;
  logic [AW-1:0] rt = '0;
  logic [DW-1:0] pc_plus4 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] result;
  logic [AW-1:0] write_reg;
  logic          branch_taken;
  logic [DW-1:0] branch_target;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model state
  int            m_cnt = 0;
  logic          m_ov = 1'b0;
  logic [DW-1:0] m_res = '0, m_btgt = '0, m_hi = '0, m_lo = '0;
  logic [DW-1:0] p_hi = '0, p_lo = '0;
  logic [AW-1:0] m_wr = '0;
  logic          m_bt = 1'b0;

  always #5 clk = ~clk;

  exe_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .sign_ext(sign_ext), .alu_src(alu_src), .reg_dst(reg_dst),
    .branch(branch), .shamt(shamt), .rd(rd), .rt(rt), .pc_plus4(pc_plus4),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .write_reg(write_reg), .branch_taken(branch_taken),
    .branch_target(branch_target), .busy(busy)
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] ext_of(logic [15:0] im, logic se);
    return se ? {{16{im[15]}}, im} : {16'h0, im};
  endfunction

  function automatic logic [DW-1:0] ref_alu(logic [3:0] o, logic [DW-1:0] a,
                                            logic [DW-1:0] b, logic [4:0] sh,
                                            logic [DW-1:0] hv, logic [DW-1:0] lv);
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  return b << sh;
      4'd8:  return b >> sh;
      4'd9:  return $unsigned(sb >>> sh);
      4'd14: return hv;
      4'd15: return lv;
      default: return '0;
    endcase
  endfunction

  // Returns {HI, LO}.
  function automatic logic [63:0] ref_muldiv(logic [3:0] o, logic [DW-1:0] a, logic [DW-1:0] b);
    longint sp;
    int sa, sb;
    logic [DW-1:0] q, r;
    sa = a;
    sb = b;
    case (o)
      4'd10: begin sp = longint'(sa) * longint'(sb); return sp; end
      4'd11: return {32'h0, a} * {32'h0, b};
      4'd12: begin
        if (b == 0) begin q = '1; r = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = '0; end
        else begin q = sa / sb; r = sa % sb; end
        return {r, q};
      end
      default: begin
        if (b == 0) begin q = '1; r = a; end
        else begin q = a / b; r = a % b; end
        return {r, q};
      end
    endcase
  endfunction

  // Transaction-level model, advanced on each rising edge.
  initial begin : model
    logic acc;
    logic [63:0] hl;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_cnt = 0; m_ov = 1'b0; m_res = '0; m_wr = '0; m_bt = 1'b0;
        m_btgt = '0; m_hi = '0; m_lo = '0;
      end else begin
        acc = in_valid && (m_cnt == 0) && (!m_ov || out_ready);
        if (m_ov && out_ready) m_ov = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_hi = p_hi; m_lo = p_lo;
            m_ov = 1'b1; m_res = p_lo; m_wr = '0; m_bt = 1'b0; m_btgt = '0;
          end
        end else if (acc) begin
          if (op >= 4'd10 && op <= 4'd13) begin
            hl = ref_muldiv(op, rs_data, rt_data);
            p_hi = hl[63:32];
            p_lo = hl[31:0];
            m_cnt = (op >= 4'd12) ? DW : MC;
          end else begin
            m_res  = ref_alu(op, rs_data, alu_src ? ext_of(imm, sign_ext) : rt_data,
                             shamt, m_hi, m_lo);
            m_wr   = branch ? '0 : (reg_dst ? rd : rt);
            m_bt   = branch && (rs_data == rt_data);
            m_btgt = pc_plus4 + (ext_of(imm, sign_ext) << 2);
            m_ov   = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("in_ready", in_ready, (m_cnt == 0) && (!m_ov || out_ready));
        chk("busy", busy, m_cnt > 0);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
          chk("result", result, m_res);
          chk("write_reg", write_reg, m_wr);
          chk("branch_taken", branch_taken, m_bt);
          chk("branch_target", branch_target, m_btgt);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [15:0] im = 16'h0, input logic se = 1'b0,
                       input logic as = 1'b0, input logic rdst = 1'b1,
                       input logic br = 1'b0, input logic [4:0] sh = 5'd0,
                       input logic [AW-1:0] rdv = 5'd3, input logic [AW-1:0] rtv = 5'd4,
                       input logic [DW-1:0] pc = 32'h0);
    int n;
    logic ok;
    @(posedge clk); #2;
    op = o; rs_data = a; rt_data = b; imm = im; sign_ext = se; alu_src = as;
    reg_dst = rdst; branch = br; shamt = sh; rd = rdv; rt = rtv; pc_plus4 = pc;
    in_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      n++;
    end
    chk("accept", ok, 1'b1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [DW-1:0] r, output int nb);
    int n;
    logic got;
    nb = 0;
    n = 0;
    got = 1'b0;
    r = '0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        r = result;
      end else if (busy) begin
        nb++;
      end
      n++;
    end
    chk("out_arrives", got, 1'b1);
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [31:0] a, b;
    logic [15:0] im;
    logic        se, as;
    logic [4:0]  sh;
    logic [31:0] e;
  } vec_t;

  vec_t vecs[14];

  initial begin : stim
    logic [DW-1:0] r;
    int nb;

    vecs[0]  = '{4'd0, 32'hFFFF_FFFF, 32'h1,         16'h0,    1'b0, 1'b0, 5'd0,  32'h0};
    vecs[1]  = '{4'd6, 32'hFFFF_FFFF, 32'h1,         16'h0,    1'b0, 1'b0, 5'd0,  32'h1};
    vecs[2]  = '{4'd1, 32'h5,         32'h7,         16'h0,    1'b0, 1'b0, 5'd0,  32'hFFFF_FFFE};
    vecs[3]  = '{4'd2, 32'hF0F0_F0F0, 32'h0,         16'h0FF0, 1'b0, 1'b1, 5'd0,  32'h0000_00F0};
    vecs[4]  = '{4'd3, 32'h1234_0000, 32'h0,         16'h8001, 1'b0, 1'b1, 5'd0,  32'h1234_8001};
    vecs[5]  = '{4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 16'h0,    1'b0, 1'b0, 5'd0,  32'hF0F0_0F0F};
    vecs[6]  = '{4'd5, 32'h0,         32'h0,         16'h0,    1'b0, 1'b0, 5'd0,  32'hFFFF_FFFF};
    vecs[7]  = '{4'd7, 32'h0,         32'h1,         16'h0,    1'b0, 1'b0, 5'd31, 32'h8000_0000};
    vecs[8]  = '{4'd8, 32'h0,         32'h8000_0000, 16'h0,    1'b0, 1'b0, 5'd4,  32'h0800_0000};
    vecs[9]  = '{4'd9, 32'h0,         32'h8000_0000, 16'h0,    1'b0, 1'b0, 5'd31, 32'hFFFF_FFFF};
    vecs[10] = '{4'd0, 32'hA,         32'h0,         16'hFFFF, 1'b1, 1'b1, 5'd0,  32'h9};
    vecs[11] = '{4'd6, 32'h1,         32'hFFFF_FFFF, 16'h0,    1'b0, 1'b0, 5'd0,  32'h0};
    vecs[12] = '{4'd6, 32'h5,         32'h5,         16'h0,    1'b0, 1'b0, 5'd0,  32'h0};
    vecs[13] = '{4'd0, 32'h7FFF_FFFF, 32'h1,         16'h0,    1'b0, 1'b0, 5'd0,  32'h8000_0000};

    // Reset state
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_write_reg", write_reg, 5'h0);
    chk("rst_branch_taken", branch_taken, 1'b0);
    chk("rst_branch_target", branch_target, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0;

    // ALU vectors, each result one cycle after accept
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].se, vecs[i].as,
            1'b1, 1'b0, vecs[i].sh);
      wait_out(r, nb);
      chk($sformatf("alu_vec%0d", i), r, vecs[i].e);
      chk($sformatf("alu_lat%0d", i), nb, 0);
    end

    // reg_dst=0 picks rt
    issue(4'd0, 32'h1, 32'h2, 16'h0, 1'b0, 1'b0, 1'b0);
    wait_out(r, nb);
    chk("rt_dest", write_reg, 5'd4);

    // MULT 0xFFFFFFFF x 2
    issue(4'd10, 32'hFFFF_FFFF, 32'h2);
    wait_out(r, nb);
    chk("mult_busy_cycles", nb, 4);
    chk("mult_lo", r, 32'hFFFF_FFFE);
    chk("mult_wr", write_reg, 5'd0);
    issue(4'd14, 32'h0, 32'h0);
    wait_out(r, nb);
    chk("mfhi_after_mult", r, 32'hFFFF_FFFF);
    issue(4'd15, 32'h0, 32'h0);
    wait_out(r, nb);
    chk("mflo_after_mult", r, 32'hFFFF_FFFE);

    // MULTU 0xFFFFFFFF^2
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(r, nb);
    chk("multu_lo", r, 32'h0000_0001);
    issue(4'd14, 32'h0, 32'h0);
    wait_out(r, nb);
    chk("multu_hi", r, 32'hFFFF_FFFE);

    // DIV -7/2
    issue(4'd12, 32'hFFFF_FFF9, 32'h2);
    wait_out(r, nb);
    chk("div_busy_cycles", nb, 32);
    chk("div_lo", r, 32'hFFFF_FFFD);
    issue(4'd14, 32'h0, 32'h0);
    wait_out(r, nb);
    chk("div_hi", r, 32'hFFFF_FFFF);

    // DIVU 7/0
    issue(4'd13, 32'h7, 32'h0);
    wait_out(r, nb);
    chk("divu0_busy_cycles", nb, 32);
    chk("divu0_lo", r, 32'hFFFF_FFFF);
    issue(4'd14, 32'h0, 32'h0);
    wait_out(r, nb);
    chk("divu0_hi", r, 32'h7);

    // Most-negative / -1
    issue(4'd12, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_out(r, nb);
    chk("div_ovf_lo", r, 32'h8000_0000);
    issue(4'd14, 32'h0, 32'h0);
    wait_out(r, nb);
    chk("div_ovf_hi", r, 32'h0);

    // DIV 7/-2 and signed divide by zero
    issue(4'd12, 32'h7, 32'hFFFF_FFFE);
    wait_out(r, nb);
    chk("div_7_m2_lo", r, 32'hFFFF_FFFD);
    issue(4'd14, 32'h0, 32'h0);
    wait_out(r, nb);
    chk("div_7_m2_hi", r, 32'h1);
    issue(4'd12, 32'hFFFF_FFF8, 32'h0);
    wait_out(r, nb);
    chk("div0_signed_lo", r, 32'hFFFF_FFFF);
    issue(4'd14, 32'h0, 32'h0);
    wait_out(r, nb);
    chk("div0_signed_hi", r, 32'hFFFF_FFF8);

    // BEQ taken and not taken
    issue(4'd0, 32'h5, 32'h5, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'd7, 5'd4, 32'h100);
    wait_out(r, nb);
    chk("beq_taken", branch_taken, 1'b1);
    chk("beq_target", branch_target, 32'hFC);
    chk("beq_wr", write_reg, 5'd0);
    issue(4'd0, 32'h5, 32'h6, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'd7, 5'd4, 32'h200);
    wait_out(r, nb);
    chk("bne_taken", branch_taken, 1'b0);
    chk("bne_target", branch_target, 32'h210);

    // Backpressure: hold result, refuse new op, then accept with no bubble
    @(posedge clk); #2;
    out_ready = 1'b0;
    issue(4'd0, 32'd10, 32'd20);
    op = 4'd1; rs_data = 32'd50; rt_data = 32'd8; alu_src = 1'b0; branch = 1'b0;
    reg_dst = 1'b1; rd = 5'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_result", result, 32'd30);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1'b1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", out_valid, 1'b1);
    chk("bp_next_result", result, 32'd42);
    chk("bp_next_wr", write_reg, 5'd9);

    // Reset in the middle of a divide
    issue(4'd12, 32'd100, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", out_valid, 1'b0);
    issue(4'd15, 32'h0, 32'h0);
    wait_out(r, nb);
    chk("midrst_mflo", r, 32'h0);
    issue(4'd14, 32'h0, 32'h0);
    wait_out(r, nb);
    chk("midrst_mfhi", r, 32'h0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exe_stage_pipe.md
EXE_STAGE_PIPE -- requirements
Module: exe_stage_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the datapath width (8..64).
REQ-002 The block SHALL have parameter REG_AW, default 5, giving the register-address width.
REQ-003 The block SHALL have parameter MUL_CYCLES, default 4, giving the multiply latency in cycles after accept (>=1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: an ID/EX operation is presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the operation this cycle.
REQ-008 The block SHALL have port op, input, 4 bits: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, 9 SRA, 10 MULT, 11 MULTU, 12 DIV, 13 DIVU, 14 MFHI, 15 MFLO.
REQ-009 The block SHALL have ports rs_data and rt_data, input, DATA_W each: the operands.
REQ-010 The block SHALL have port imm, input, 16 bits: the immediate.
REQ-011 The block SHALL have port sign_ext, input, 1 bit: 1 sign-extends imm, 0 zero-extends it.
REQ-012 The block SHALL have port alu_src, input, 1 bit: 1 makes operand B the extended imm, 0 makes it rt_data.
REQ-013 The block SHALL have ports reg_dst, input, 1 bit, and branch, input, 1 bit: destination select and branch-on-equal flag.
REQ-014 The block SHALL have port shamt, input, 5 bits: the shift amount.
REQ-015 The block SHALL have ports rd and rt, input, REG_AW each: the candidate destinations.
REQ-016 The block SHALL have port pc_plus4, input, DATA_W: the sequential PC.
REQ-017 The block SHALL have port out_valid, output, 1 bit: an EX/MEM result is held.
REQ-018 The block SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-019 The block SHALL have port result, output, DATA_W: the result.
REQ-020 The block SHALL have port write_reg, output, REG_AW: the destination; 0 means no writeback.
REQ-021 The block SHALL have ports branch_taken, output, 1 bit, and branch_target, output, DATA_W.
REQ-022 The block SHALL have port busy, output, 1 bit: a multiply or divide is in progress.

Function
REQ-023 The FSM SHALL have states IDLE, MUL and DIV; the handshake rule is in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-024 An operation SHALL be accepted on a cycle with in_valid && in_ready; an ALU op (0-9) or MFHI/MFLO SHALL load the output register at that edge, giving 1-cycle latency.
REQ-025 The output register SHALL hold result, write_reg, branch_taken and branch_target, and SHALL stay stable while out_valid && !out_ready.
REQ-026 ADD and SUB SHALL wrap modulo 2^DATA_W with no overflow trap; SLT SHALL be a signed compare producing 1 or 0.
REQ-027 SLL, SRL and SRA SHALL shift operand B by shamt; shamt >= DATA_W SHALL yield 0, or the replicated sign bit for SRA.
REQ-028 write_reg SHALL be rd when reg_dst=1 and rt otherwise, and SHALL be forced to 0 for MULT, MULTU, DIV, DIVU and branch ops.
REQ-029 branch_taken SHALL equal branch && (rs_data == rt_data).
REQ-030 branch_target SHALL equal pc_plus4 + (ext_imm << 2), truncated to DATA_W.
REQ-031 MULT/MULTU SHALL go IDLE->MUL, count MUL_CYCLES cycles, write the 2*DATA_W product to {HI,LO}, load the output register with result=LO and write_reg=0, and return to IDLE.
REQ-032 DIV/DIVU SHALL go IDLE->DIV, run a 1-bit-per-cycle restoring divider for DATA_W cycles, write LO=quotient and HI=remainder, then emit and return to IDLE as for multiply.
REQ-033 Signed divide SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-034 Divide by zero SHALL complete in the same cycle count with LO = all ones and HI = the dividend; the most-negative value / -1 SHALL give LO = the dividend and HI = 0.
REQ-035 busy SHALL be 1 exactly in the MUL and DIV states.
REQ-036 MFHI/MFLO SHALL return the HI/LO values committed by the last completed multiply or divide.
REQ-037 When out_valid && out_ready and a new accept occur in the same cycle, the new result SHALL replace the old with no bubble.

Reset
REQ-038 With rst=1 at a clock edge: state=IDLE, out_valid=0, result=0, write_reg=0, branch_taken=0, branch_target=0, HI=0, LO=0, busy=0.
REQ-039 Reset asserted during MUL or DIV SHALL abort the operation, discard partial results and leave HI/LO at 0.

Verification
REQ-040 ADD 0xFFFFFFFF+1, out_ready=1 -> result 0 one cycle after accept; SLT -1,1 -> 1.
REQ-041 MULT 0xFFFFFFFF x 2 -> busy for 4 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; then MFHI returns 0xFFFFFFFF.
REQ-042 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7, both after 32 busy cycles.
REQ-043 BEQ rs=rt=5, imm=0xFFFF, pc_plus4=0x100 -> branch_taken=1, branch_target=0xFC, write_reg=0.
REQ-044 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; then out_ready=1 -> next op accepted the same cycle.
REQ-045 rst pulse mid-DIV -> next cycle busy=0, out_valid=0; a following MFLO returns 0.
